range_step_counter: RTL and testbench



---
 rtl/range_cnt_pkg.sv | 40 ++++
 rtl/range_step_counter_event_qual.sv | 34 +++
 rtl/range_step_counter.sv | 152 +++++++++++++++
 tb/tb_range_step_counter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_cnt_pkg.sv
// ----------------------------------------------------------------------------
// range_cnt_pkg
// Shared constants and the parameter-legality check for range_step_counter
// and its event_qual sub-block.
//   MODE_SAT / MODE_WRAP   : values for WRAP_MODE
//   MODE_LEVEL / MODE_EDGE : values for EDGE_MODE
//   range_cnt_params_ok()  : 1 when a parameter set is legal
// ----------------------------------------------------------------------------
package range_cnt_pkg;

  localparam int unsigned MODE_SAT   = 0;
  localparam int unsigned MODE_WRAP  = 1;
  localparam int unsigned MODE_LEVEL = 0;
  localparam int unsigned MODE_EDGE  = 1;

  function automatic bit range_cnt_params_ok(
    input int unsigned width,
    input int unsigned min_val,
    input int unsigned max_val,
    input int unsigned step,
    input int unsigned evt_w,
    input int unsigned wrap_mode,
    input int unsigned edge_mode,
    input int unsigned lap_w
  );
    bit ok;
    ok = 1'b1;
    if (width < 1 || width > 31)                                   ok = 1'b0;
    if (min_val > max_val)                                         ok = 1'b0;
    if (longint'(max_val) >= (longint'(1) << width))               ok = 1'b0;
    if (step < 1)                                                  ok = 1'b0;
    if (longint'(step) > longint'(max_val) - longint'(min_val) + 1) ok = 1'b0;
    if (evt_w < 1)                                                 ok = 1'b0;
    if (wrap_mode > MODE_WRAP)                                     ok = 1'b0;
    if (edge_mode > MODE_EDGE)                                     ok = 1'b0;
    if (lap_w < 1)                                                 ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/range_step_counter_event_qual.sv
// ----------------------------------------------------------------------------
// event_qual
// Qualifies a game event and produces the advance strobe for the counter.
//   clk_1H  in         game tick clock
//   endf    in         end-of-frame gate
//   seg_out in  EVT_W  event value, nonzero = event present
//   adv     out        advance strobe (level or rising-edge of the qualifier)
// ----------------------------------------------------------------------------
module event_qual
  import range_cnt_pkg::*;
#(
  parameter int unsigned EVT_W     = 10,
  parameter int unsigned EDGE_MODE = MODE_LEVEL
) (
  input  logic             clk_1H,
  input  logic             endf,
  input  logic [EVT_W-1:0] seg_out,
  output logic             adv
);

  logic q;
  logic q_q;

  assign q = endf && (seg_out != '0);

  // q_q tracks q even while the counter is held in reset, so a qualifier that
  // is already high at reset release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk_1H) begin
    q_q <= q;
  end

  assign adv = (EDGE_MODE == MODE_EDGE) ? (q && !q_q) : q;

endmodule

// File: rtl/range_step_counter.sv
// ----------------------------------------------------------------------------
// range_step_counter
// Bounded MIN_VAL..MAX_VAL counter stepping by STEP, up or down, on qualified
// game events; wraps or saturates at the bounds, pulses on a bound hit and
// counts wraps (laps) for the HUD / seven-segment path.
//   clk_1H    in          game tick clock
//   reset     in          synchronous active-high reset
//   endf      in          end-of-frame gate
//   seg_out   in  EVT_W   event value (nonzero = event)
//   dir       in          0 = up, 1 = down (sampled on advance cycles only)
//   clear     in          synchronous return to MIN_VAL, laps cleared
//   load      in          (RANGE_STEP_COUNTER_LOAD_EN only) load load_val
//   load_val  in  WIDTH   (RANGE_STEP_COUNTER_LOAD_EN only) value to load
//   seg_out7  out WIDTH   registered count
//   tc_pulse  out         one-cycle pulse after a wrap or clamp
//   laps      out LAP_W   saturating wrap counter
// Optional feature macro: RANGE_STEP_COUNTER_LOAD_EN
// ----------------------------------------------------------------------------
module range_step_counter
  import range_cnt_pkg::*;
#(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned MIN_VAL   = 10,
  parameter int unsigned MAX_VAL   = 18,
  parameter int unsigned STEP      = 1,
  parameter int unsigned EVT_W     = 10,
  parameter int unsigned WRAP_MODE = MODE_WRAP,
  parameter int unsigned EDGE_MODE = MODE_LEVEL,
  parameter int unsigned LAP_W     = 4
) (
  input  logic             clk_1H,
  input  logic             reset,
  input  logic             endf,
  input  logic [EVT_W-1:0] seg_out,
  input  logic             dir,
  input  logic             clear,
`ifdef RANGE_STEP_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] seg_out7,
  output logic             tc_pulse,
  output logic [LAP_W-1:0] laps
);

  localparam bit PARAMS_OK = range_cnt_params_ok(WIDTH, MIN_VAL, MAX_VAL, STEP,
                                                 EVT_W, WRAP_MODE, EDGE_MODE, LAP_W);

  if (!PARAMS_OK) begin : g_bad_params
    $error("range_step_counter: illegal parameter set");
  end

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

  typedef struct packed {
    logic             hit;
    logic [WIDTH-1:0] cnt;
  } step_t;

  // One advance from cnt. Comparisons are done one bit wider than the count so
  // cnt+STEP and MIN_VAL+STEP cannot overflow. hit flags a wrap or a clamp.
  // An out-of-range count (only reachable through a load) snaps to MIN_VAL
  // without counting as a bound hit.
  function automatic step_t step_sat_wrap(input logic [WIDTH-1:0] cnt, input logic down);
    step_t          r;
    logic [WIDTH:0] c;
    logic [WIDTH:0] sum;
    c     = {1'b0, cnt};
    sum   = c + STEP_X;
    r.hit = 1'b0;
    r.cnt = MIN_W;
    if (c < MIN_X || c > MAX_X) begin
      r.cnt = MIN_W;
    end else if (!down) begin
      if (sum <= MAX_X) begin
        r.cnt = sum[WIDTH-1:0];
      end else begin
        r.hit = 1'b1;
        r.cnt = (WRAP_MODE == MODE_WRAP) ? MIN_W : MAX_W;
      end
    end else begin
      if (c >= MIN_X + STEP_X) begin
        r.cnt = cnt - STEP_W;
      end else begin
        r.hit = 1'b1;
        r.cnt = (WRAP_MODE == MODE_WRAP) ? MAX_W : MIN_W;
      end
    end
    return r;
  endfunction

  logic             adv;
  step_t            nxt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [LAP_W-1:0] laps_q, laps_d;

  event_qual #(
    .EVT_W     (EVT_W),
    .EDGE_MODE (EDGE_MODE)
  ) u_event_qual (
    .clk_1H  (clk_1H),
    .endf    (endf),
    .seg_out (seg_out),
    .adv     (adv)
  );

  always_comb begin
    nxt    = step_sat_wrap(cnt_q, dir);
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    laps_d = laps_q;
    if (clear) begin
      cnt_d  = MIN_W;
      laps_d = '0;
    end
`ifdef RANGE_STEP_COUNTER_LOAD_EN
    else if (load) begin
      cnt_d = load_val;
    end
`endif
    else if (adv) begin
      cnt_d = nxt.cnt;
      tc_d  = nxt.hit;
      if (nxt.hit && (WRAP_MODE == MODE_WRAP) && (laps_q != {LAP_W{1'b1}})) begin
        laps_d = laps_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_1H) begin
    if (reset) begin
      cnt_q  <= MIN_W;
      tc_q   <= 1'b0;
      laps_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      laps_q <= laps_d;
    end
  end

  assign seg_out7 = cnt_q;
  assign tc_pulse = tc_q;
  assign laps     = laps_q;

endmodule

// File: tb/tb_range_step_counter.sv
module tb_range_step_counter;

  localparam int NI   = 3;
  localparam int MINV = 10;
  localparam int MAXV = 18;
  localparam int LAPM = 15;

  logic       clk_1H  = 1'b0;
  logic       reset   = 1'b1;
  logic       endf    = 1'b0;
  logic [9:0] seg_out = '0;
  logic       dir     = 1'b0;
  logic       clear   = 1'b0;
`ifdef RANGE_STEP_COUNTER_LOAD_EN
  logic       load     = 1'b0;
  logic [4:0] load_val = '0;
`endif

  logic [4:0] o_cnt  [NI];
  logic       o_tc   [NI];
  logic [3:0] o_laps [NI];

  // instance 0: defaults; 1: saturate, STEP=3; 2: edge-qualified
  int cfg_step [NI] = '{1, 3, 1};
  int cfg_wrap [NI] = '{1, 0, 1};
  int cfg_edge [NI] = '{0, 0, 1};

  int m_cnt  [NI];
  int m_laps [NI];
  int m_tc   [NI];
  bit m_qprev[NI];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_1H = ~clk_1H;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    range_step_counter #(
      .WIDTH     (5),
      .MIN_VAL   (10),
      .MAX_VAL   (18),
      .STEP      ((g == 1) ? 3 : 1),
      .EVT_W     (10),
      .WRAP_MODE ((g == 1) ? 0 : 1),
      .EDGE_MODE ((g == 2) ? 1 : 0),
      .LAP_W     (4)
    ) u_dut (
      .clk_1H   (clk_1H),
      .reset    (reset),
      .endf     (endf),
      .seg_out  (seg_out),
      .dir      (dir),
      .clear    (clear),
`ifdef RANGE_STEP_COUNTER_LOAD_EN
      .load     (load),
      .load_val (load_val),
`endif
      .seg_out7 (o_cnt[g]),
      .tc_pulse (o_tc[g]),
      .laps     (o_laps[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference behaviour of one instance for the inputs present this cycle.
  function automatic void model_step(input int i);
    bit q;
    bit adv;
    bit ld;
    int ldv;
    int c;
    ld  = 1'b0;
    ldv = 0;
`ifdef RANGE_STEP_COUNTER_LOAD_EN
    ld  = load;
    ldv = int'(load_val);
`endif
    q   = endf && (seg_out != 0);
    adv = cfg_edge[i] ? (q && !m_qprev[i]) : q;
    m_qprev[i] = q;
    m_tc[i] = 0;
    c = m_cnt[i];
    if (reset || clear) begin
      m_cnt[i]  = MINV;
      m_laps[i] = 0;
    end else if (ld) begin
      m_cnt[i] = ldv;
    end else if (adv) begin
      if (c < MINV || c > MAXV) begin
        m_cnt[i] = MINV;
      end else if (!dir) begin
        if (c + cfg_step[i] <= MAXV) m_cnt[i] = c + cfg_step[i];
        else begin
          m_tc[i]  = 1;
          m_cnt[i] = cfg_wrap[i] ? MINV : MAXV;
          if (cfg_wrap[i] && m_laps[i] < LAPM) m_laps[i]++;
        end
      end else begin
        if (c - cfg_step[i] >= MINV) m_cnt[i] = c - cfg_step[i];
        else begin
          m_tc[i]  = 1;
          m_cnt[i] = cfg_wrap[i] ? MAXV : MINV;
          if (cfg_wrap[i] && m_laps[i] < LAPM) m_laps[i]++;
        end
      end
    end
  endfunction

  task automatic tick(input string tag);
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk_1H);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i),  int'(o_cnt[i]),  m_cnt[i]);
      chk($sformatf("%s_tc%0d", tag, i),   int'(o_tc[i]),   m_tc[i]);
      chk($sformatf("%s_laps%0d", tag, i), int'(o_laps[i]), m_laps[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick("rst");
    reset = 1'b0;
  endtask

  int exp_up  [10] = '{11, 12, 13, 14, 15, 16, 17, 18, 10, 11};
  int exp_sat [5]  = '{13, 16, 18, 18, 18};
  int plen    [3]  = '{1, 3, 7};

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_laps[i] = 0; m_tc[i] = 0; m_qprev[i] = 1'b0;
    end

    // reset state
    reset = 1'b1;
    tick("rst");
    tick("rst");
    chk("rst_cnt", int'(o_cnt[0]), 10);
    chk("rst_tc", int'(o_tc[0]), 0);
    chk("rst_laps", int'(o_laps[0]), 0);
    reset = 1'b0;

    // held event, default wrap counter and saturating STEP=3 counter
    endf = 1'b1; seg_out = 10'd5; dir = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick("up");
      chk("up_seq", int'(o_cnt[0]), exp_up[k]);
      chk("up_tcpulse", int'(o_tc[0]), (k == 8) ? 1 : 0);
      if (k < 5) begin
        chk("sat_seq", int'(o_cnt[1]), exp_sat[k]);
        chk("sat_tcpulse", int'(o_tc[1]), (k >= 2) ? 1 : 0);
      end
    end
    chk("up_laps", int'(o_laps[0]), 1);
    chk("sat_laps", int'(o_laps[1]), 0);
    chk("edge_once", int'(o_cnt[2]), 11);

    // zero event value never advances
    endf = 1'b0;
    do_reset();
    endf = 1'b1; seg_out = '0;
    for (int k = 0; k < 20; k++) tick("zero");
    chk("zero_cnt", int'(o_cnt[0]), 10);
    chk("zero_tc", int'(o_tc[0]), 0);

    // down wrap from MIN, then clear together with an advance
    endf = 1'b0;
    do_reset();
    endf = 1'b1; seg_out = 10'd1; dir = 1'b1;
    tick("down");
    chk("down_cnt", int'(o_cnt[0]), 18);
    chk("down_laps", int'(o_laps[0]), 1);
    chk("down_tc", int'(o_tc[0]), 1);
    clear = 1'b1;
    tick("clr");
    clear = 1'b0;
    chk("clr_cnt", int'(o_cnt[0]), 10);
    chk("clr_laps", int'(o_laps[0]), 0);
    chk("clr_tc", int'(o_tc[0]), 0);

    // edge qualification: pulses of 1, 3, 7 cycles
    endf = 1'b0; dir = 1'b0;
    do_reset();
    seg_out = 10'd7;
    for (int p = 0; p < 3; p++) begin
      endf = 1'b1;
      for (int k = 0; k < plen[p]; k++) tick("edge_hi");
      endf = 1'b0;
      tick("edge_lo");
      tick("edge_lo");
    end
    chk("edge_three", int'(o_cnt[2]), 13);

    // qualifier held high across reset release does not count in edge mode
    endf = 1'b1;
    reset = 1'b1;
    tick("hold_rst");
    tick("hold_rst");
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick("hold");
    chk("hold_edge", int'(o_cnt[2]), 10);
    endf = 1'b0;
    tick("hold");
    endf = 1'b1;
    tick("hold");
    chk("hold_reedge", int'(o_cnt[2]), 11);

    // reset in the middle of counting
    seg_out = 10'd3;
    for (int k = 0; k < 4; k++) tick("mid");
    reset = 1'b1;
    tick("mid_rst");
    reset = 1'b0;
    chk("mid_rst_cnt", int'(o_cnt[0]), 10);

    // lap counter saturation
    for (int k = 0; k < 170; k++) tick("lapsat");
    chk("lap_sat", int'(o_laps[0]), 15);

`ifdef RANGE_STEP_COUNTER_LOAD_EN
    // out-of-range load, then the next advance returns to MIN_VAL
    endf = 1'b0;
    do_reset();
    load = 1'b1; load_val = 5'd25;
    tick("load");
    load = 1'b0;
    chk("load_cnt", int'(o_cnt[0]), 25);
    endf = 1'b1; seg_out = 10'd1;
    tick("load_adv");
    chk("load_back", int'(o_cnt[0]), 10);
`endif

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 199) == 0);
      clear   = ($urandom_range(0, 39) == 0);
      endf    = ($urandom_range(0, 3) != 0);
      seg_out = ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
      dir     = ($urandom_range(0, 2) == 0);
`ifdef RANGE_STEP_COUNTER_LOAD_EN
      load     = ($urandom_range(0, 49) == 0);
      load_val = 5'($urandom_range(0, 31));
`endif
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
